// File: rtl/cache_evict_writer_if.sv
// Bus bundle for cache_evict_writer: victim queue input, tag/data array read port,
// memory write channel and dirty-clear strobe. master = the writer, slave = its environment.
interface cache_evict_writer_if #(
  parameter int IDX_W      = 10,
  parameter int WORD_W     = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = ADDR_W - IDX_W - WSEL_W - $clog2(WORD_W/8);

  logic              evict_valid_i;
  logic [IDX_W-1:0]  evict_idx_i;
  logic              evict_ready_o;
  logic              rd_en_o;
  logic [IDX_W-1:0]  rd_idx_o;
  logic [WSEL_W-1:0] rd_word_o;
  logic [TAG_W-1:0]  rd_tag_i;
  logic              rd_dirty_i;
  logic [WORD_W-1:0] rd_data_i;
  logic              mem_valid_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_data_o;
  logic              mem_last_o;
  logic              mem_ready_i;
  logic              clr_dirty_o;
  logic [IDX_W-1:0]  clr_idx_o;

  modport master (
    input  evict_valid_i, evict_idx_i, rd_tag_i, rd_dirty_i, rd_data_i, mem_ready_i,
    output evict_ready_o, rd_en_o, rd_idx_o, rd_word_o, mem_valid_o, mem_addr_o,
           mem_data_o, mem_last_o, clr_dirty_o, clr_idx_o
  );
  modport slave (
    output evict_valid_i, evict_idx_i, rd_tag_i, rd_dirty_i, rd_data_i, mem_ready_i,
    input  evict_ready_o, rd_en_o, rd_idx_o, rd_word_o, mem_valid_o, mem_addr_o,
           mem_data_o, mem_last_o, clr_dirty_o, clr_idx_o
  );
endinterface

// File: rtl/cache_evict_writer.sv
// Queues LRU victims, reads tag/dirty/data from the cache arrays and writes dirty lines
// back to memory. Define EVICT_STATS_EN to add saturating eviction/writeback counters.
module cache_evict_writer #(
  parameter int IDX_W      = 10,
  parameter int WORD_W     = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  cache_evict_writer_if.master bus,
  output logic                 busy_o
`ifdef EVICT_STATS_EN
  ,
  output logic [31:0]          stat_evicts_o,
  output logic [31:0]          stat_wbacks_o
`endif
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = $clog2(WORD_W/8);
  localparam int TAG_W  = ADDR_W - IDX_W - WSEL_W - OFF_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_TAG, S_RD, S_WR, S_CLR} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0]  fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]  cur_idx_q, cur_idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WSEL_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              first_q, first_d;
  logic              full, push, pop, last_word;
  logic [WORD_W-1:0] beat_data;

  assign full      = (cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push      = bus.evict_valid_i && !full;
  assign last_word = (word_q == WSEL_W'(LINE_WORDS-1));
  // The read returns data on the first WR cycle; afterwards the captured copy holds the beat.
  assign beat_data = first_q ? bus.rd_data_i : data_q;

  assign bus.evict_ready_o = !full;
  assign busy_o            = (state_q != S_IDLE) || (cnt_q != '0);

  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wptr_q] = bus.evict_idx_i;
      wptr_d         = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cur_idx_d       = cur_idx_q;
    tag_d           = tag_q;
    word_d          = word_q;
    data_d          = data_q;
    first_d         = 1'b0;
    pop             = 1'b0;
    bus.rd_en_o     = 1'b0;
    bus.rd_idx_o    = '0;
    bus.rd_word_o   = '0;
    bus.mem_valid_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_data_o  = '0;
    bus.mem_last_o  = 1'b0;
    bus.clr_dirty_o = 1'b0;
    bus.clr_idx_o   = '0;
    case (state_q)
      S_IDLE: if (cnt_q != '0) begin
        pop          = 1'b1;
        cur_idx_d    = fifo_q[rptr_q];
        word_d       = '0;
        bus.rd_en_o  = 1'b1;
        bus.rd_idx_o = fifo_q[rptr_q];
        state_d      = S_TAG;
      end
      S_TAG: begin
        tag_d   = bus.rd_tag_i;
        state_d = bus.rd_dirty_i ? S_RD : S_IDLE;
      end
      S_RD: begin
        bus.rd_en_o   = 1'b1;
        bus.rd_idx_o  = cur_idx_q;
        bus.rd_word_o = word_q;
        first_d       = 1'b1;
        state_d       = S_WR;
      end
      S_WR: begin
        data_d          = beat_data;
        bus.mem_valid_o = 1'b1;
        bus.mem_addr_o  = {tag_q, cur_idx_q, word_q, {OFF_W{1'b0}}};
        bus.mem_data_o  = beat_data;
        bus.mem_last_o  = last_word;
        if (bus.mem_ready_i) begin
          if (last_word) state_d = S_CLR;
          else begin
            word_d  = word_q + WSEL_W'(1);
            state_d = S_RD;
          end
        end
      end
      S_CLR: begin
        bus.clr_dirty_o = 1'b1;
        bus.clr_idx_o   = cur_idx_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      fifo_q    <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      tag_q     <= '0;
      word_q    <= '0;
      data_q    <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      tag_q     <= tag_d;
      word_q    <= word_d;
      data_q    <= data_d;
      first_q   <= first_d;
    end
  end

`ifdef EVICT_STATS_EN
  logic [31:0] evicts_q, evicts_d, wbacks_q, wbacks_d;

  always_comb begin
    evicts_d = evicts_q;
    wbacks_d = wbacks_q;
    if (pop && evicts_q != '1)             evicts_d = evicts_q + 32'd1;
    if (bus.clr_dirty_o && wbacks_q != '1) wbacks_d = wbacks_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      evicts_q <= '0;
      wbacks_q <= '0;
    end else begin
      evicts_q <= evicts_d;
      wbacks_q <= wbacks_d;
    end
  end

  assign stat_evicts_o = evicts_q;
  assign stat_wbacks_o = wbacks_q;
`endif
endmodule
